alu_ctrl_pipe: RTL and testbench
================================

ALU_CTRL_PIPE -- requirements
Module: alu_ctrl_pipe

Interface
REQ-001 Parameter ALUOP_W, 3: ALUOp width.
REQ-002 Parameter FUNCT_W, 6: Funct width.
REQ-003 Parameter CTRL_W, 4: ALUControl width; SHALL hold every ALU_OP_* code including ALU_OP_MULT/MULTU/DIV/DIVU.
REQ-004 Parameter MD_CYCLES, 32: multi-cycle op duration in cycles, legal range 2..256.
REQ-005 Parameter CNT_W, clog2(MD_CYCLES): counter width.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rstb  in  1  asynchronous active-low reset.
REQ-009 flush  in  1  synchronous abort of any op in flight.
REQ-010 in_valid  in  1  request present.
REQ-011 in_ready  out  1  request accepted when in_valid && in_ready at clk edge.
REQ-012 alu_op  in  ALUOP_W  controller ALU op.
REQ-013 funct  in  FUNCT_W  instruction funct field.
REQ-014 out_valid  out  1  alu_ctrl/is_multi/illegal valid.
REQ-015 out_ready  in  1  consumer takes output.
REQ-016 alu_ctrl  out  CTRL_W  decoded ALU control.
REQ-017 is_multi  out  1  result is a multi-cycle op.
REQ-018 illegal  out  1  funct path hit an unrecognised funct.
REQ-019 md_busy  out  1  multi-cycle op in progress.
REQ-020 md_count  out  CNT_W  remaining multi-cycle count.

Function
REQ-021 Decode SHALL match existing controller semantics: the six direct ALUOp codes (ADD, SUB, AND, OR, XOR, SLT) map to the same-named ALU_OP_* code; any other ALUOp uses the funct table.
REQ-022 Funct table: AND, OR, XOR, NOR, SLL, SRL, SRA, SLT, ADD, SUB map to the same-named ALU_OP_*; unrecognised funct yields ALU_OP_ADD with illegal=1.
REQ-023 States SHALL be IDLE and BUSY.
REQ-024 in_ready SHALL be (state==IDLE) && (!out_valid || out_ready) && !flush.
REQ-025 Single-cycle op accepted in IDLE: alu_ctrl, is_multi=0 and illegal registered, out_valid=1 in the next cycle (latency 1).
REQ-026 Multi-cycle op (funct MULT/MULTU/DIV/DIVU on the funct path) accepted: state to BUSY, md_count loaded MD_CYCLES-1, md_busy=1, alu_ctrl registered.
REQ-027 In BUSY, md_count SHALL decrement each cycle; on the edge where md_count==0, state returns to IDLE, md_busy=0 and out_valid=1 with is_multi=1 (out_valid first high MD_CYCLES cycles after acceptance).
REQ-028 While out_valid && !out_ready, alu_ctrl, is_multi and illegal SHALL hold stable.
REQ-029 out_valid SHALL clear on out_ready unless a new request is accepted in the same cycle (back-to-back, one result per cycle).
REQ-030 flush SHALL override everything except reset: next cycle out_valid=0, state IDLE, md_count=0, md_busy=0; alu_ctrl holds.
REQ-031 md_count SHALL never wrap; requests arriving in BUSY are stalled, not dropped.

Reset
REQ-032 On rstb low, asynchronously: state IDLE, out_valid=0, alu_ctrl=ALU_OP_ADD, is_multi=0, illegal=0, md_busy=0, md_count=0.
REQ-033 After release in_ready SHALL be 1 (when flush=0); reset mid-BUSY aborts the op with no output.

Configuration
REQ-034 Macro ALU_CTRL_PIPE_MULDIV_EN: defined, REQ-026/027 apply.
REQ-035 Undefined: MULT/MULTU/DIV/DIVU are unrecognised (ALU_OP_ADD, illegal=1, latency 1); BUSY is unreachable; md_busy and md_count are tied 0.

Verification
REQ-036 Reset, then alu_op=ADD direct, in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_ctrl=ALU_OP_ADD, illegal=0.
REQ-037 Funct path, funct=0x27 (NOR), out_ready=0 for 5 cycles -> alu_ctrl=ALU_OP_NOR held stable, in_ready=0 until out_ready=1.
REQ-038 MULDIV on, MD_CYCLES=4, funct=0x1A (DIV) -> md_busy=1 for 4 cycles, md_count 3,2,1,0, then out_valid=1, is_multi=1, alu_ctrl=ALU_OP_DIV.
REQ-039 Funct=0x3F -> alu_ctrl=ALU_OP_ADD, illegal=1; with MULDIV off, funct=0x18 -> illegal=1, md_busy=0.
REQ-040 During BUSY at md_count=2, assert flush 1 cycle -> md_busy=0, out_valid never rises; repeat with rstb low -> all outputs at reset values immediately.

Source files
------------

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: registered ALU-control decoder (ALUOp + funct) with multi-cycle op tracking.
// Latency: 1 cycle for single-cycle ops; MD_CYCLES cycles for MULT/MULTU/DIV/DIVU.
// Backpressure: valid/ready on both sides; requests stall while BUSY or while a result is unconsumed.
// Build option: define ALU_CTRL_PIPE_MULDIV_EN to enable multi-cycle ops; otherwise they decode as illegal.
module alu_ctrl_pipe #(
  parameter int ALUOP_W   = 3,
  parameter int FUNCT_W   = 6,
  parameter int CTRL_W    = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = $clog2(MD_CYCLES)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ALUOP_W-1:0] alu_op,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               is_multi,
  output logic               illegal,
  output logic               md_busy,
  output logic [CNT_W-1:0]   md_count
);

  // Controller ALUOp codes; 6 and 7 select the funct table.
  localparam logic [ALUOP_W-1:0] AOP_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] AOP_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] AOP_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] AOP_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] AOP_XOR = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] AOP_SLT = ALUOP_W'(5);

  // ALU control codes.
  localparam logic [CTRL_W-1:0] ALU_OP_ADD = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] ALU_OP_SUB = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] ALU_OP_AND = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] ALU_OP_OR  = CTRL_W'(3);
  localparam logic [CTRL_W-1:0] ALU_OP_XOR = CTRL_W'(4);
  localparam logic [CTRL_W-1:0] ALU_OP_NOR = CTRL_W'(5);
  localparam logic [CTRL_W-1:0] ALU_OP_SLL = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] ALU_OP_SRL = CTRL_W'(7);
  localparam logic [CTRL_W-1:0] ALU_OP_SRA = CTRL_W'(8);
  localparam logic [CTRL_W-1:0] ALU_OP_SLT = CTRL_W'(9);

  // MIPS funct field encodings.
  localparam logic [FUNCT_W-1:0] F_SLL = FUNCT_W'(6'h00);
  localparam logic [FUNCT_W-1:0] F_SRL = FUNCT_W'(6'h02);
  localparam logic [FUNCT_W-1:0] F_SRA = FUNCT_W'(6'h03);
  localparam logic [FUNCT_W-1:0] F_ADD = FUNCT_W'(6'h20);
  localparam logic [FUNCT_W-1:0] F_SUB = FUNCT_W'(6'h22);
  localparam logic [FUNCT_W-1:0] F_AND = FUNCT_W'(6'h24);
  localparam logic [FUNCT_W-1:0] F_OR  = FUNCT_W'(6'h25);
  localparam logic [FUNCT_W-1:0] F_XOR = FUNCT_W'(6'h26);
  localparam logic [FUNCT_W-1:0] F_NOR = FUNCT_W'(6'h27);
  localparam logic [FUNCT_W-1:0] F_SLT = FUNCT_W'(6'h2A);
`ifdef ALU_CTRL_PIPE_MULDIV_EN
  localparam logic [CTRL_W-1:0]  ALU_OP_MULT  = CTRL_W'(10);
  localparam logic [CTRL_W-1:0]  ALU_OP_MULTU = CTRL_W'(11);
  localparam logic [CTRL_W-1:0]  ALU_OP_DIV   = CTRL_W'(12);
  localparam logic [CTRL_W-1:0]  ALU_OP_DIVU  = CTRL_W'(13);
  localparam logic [FUNCT_W-1:0] F_MULT  = FUNCT_W'(6'h18);
  localparam logic [FUNCT_W-1:0] F_MULTU = FUNCT_W'(6'h19);
  localparam logic [FUNCT_W-1:0] F_DIV   = FUNCT_W'(6'h1A);
  localparam logic [FUNCT_W-1:0] F_DIVU  = FUNCT_W'(6'h1B);
`endif

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_illegal;
  logic              dec_multi;
  logic              accept;
  logic              md_done;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign md_done  = (state == BUSY) && (md_count == '0) && !flush;

  // Decode ALUOp directly, falling back to the funct table for other codes.
  always_comb begin
    dec_ctrl    = ALU_OP_ADD;
    dec_illegal = 1'b0;
    dec_multi   = 1'b0;
    case (alu_op)
      AOP_ADD: dec_ctrl = ALU_OP_ADD;
      AOP_SUB: dec_ctrl = ALU_OP_SUB;
      AOP_AND: dec_ctrl = ALU_OP_AND;
      AOP_OR:  dec_ctrl = ALU_OP_OR;
      AOP_XOR: dec_ctrl = ALU_OP_XOR;
      AOP_SLT: dec_ctrl = ALU_OP_SLT;
      default: begin
        case (funct)
          F_AND:   dec_ctrl = ALU_OP_AND;
          F_OR:    dec_ctrl = ALU_OP_OR;
          F_XOR:   dec_ctrl = ALU_OP_XOR;
          F_NOR:   dec_ctrl = ALU_OP_NOR;
          F_SLL:   dec_ctrl = ALU_OP_SLL;
          F_SRL:   dec_ctrl = ALU_OP_SRL;
          F_SRA:   dec_ctrl = ALU_OP_SRA;
          F_SLT:   dec_ctrl = ALU_OP_SLT;
          F_ADD:   dec_ctrl = ALU_OP_ADD;
          F_SUB:   dec_ctrl = ALU_OP_SUB;
`ifdef ALU_CTRL_PIPE_MULDIV_EN
          F_MULT:  begin dec_ctrl = ALU_OP_MULT;  dec_multi = 1'b1; end
          F_MULTU: begin dec_ctrl = ALU_OP_MULTU; dec_multi = 1'b1; end
          F_DIV:   begin dec_ctrl = ALU_OP_DIV;   dec_multi = 1'b1; end
          F_DIVU:  begin dec_ctrl = ALU_OP_DIVU;  dec_multi = 1'b1; end
`endif
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: enter BUSY on a multi-cycle accept, leave when the count expires or on flush.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && dec_multi) state_nxt = BUSY;
        BUSY:    if (md_count == '0) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output register: load on accept, publish multi-cycle result at count expiry, clear when consumed.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      out_valid <= 1'b0;
      alu_ctrl  <= ALU_OP_ADD;
      is_multi  <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= !dec_multi;
      alu_ctrl  <= dec_ctrl;
      is_multi  <= 1'b0;
      illegal   <= dec_illegal;
    end else if (md_done) begin
      out_valid <= 1'b1;
      is_multi  <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ALU_CTRL_PIPE_MULDIV_EN
  // Remaining-cycle counter: loaded on a multi-cycle accept, counts down to zero without wrapping.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb)                              md_count <= '0;
    else if (flush)                         md_count <= '0;
    else if (accept && dec_multi)           md_count <= CNT_W'(MD_CYCLES - 1);
    else if (state == BUSY && md_count != '0) md_count <= md_count - CNT_W'(1);
  end

  assign md_busy = (state == BUSY);
`else
  assign md_count = '0;
  assign md_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
module tb_alu_ctrl_pipe;
  localparam int MD = 4;
  localparam int CW = $clog2(MD);

  // Expected ALU control codes.
  localparam logic [3:0] C_ADD = 4'd0, C_SUB = 4'd1, C_AND = 4'd2, C_OR = 4'd3, C_XOR = 4'd4;
  localparam logic [3:0] C_NOR = 4'd5, C_SLL = 4'd6, C_SRL = 4'd7, C_SRA = 4'd8, C_SLT = 4'd9;
  localparam logic [3:0] C_MULT = 4'd10, C_MULTU = 4'd11, C_DIV = 4'd12, C_DIVU = 4'd13;

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    alu_op = 3'd0;
  logic [5:0]    funct = 6'd0;
  logic          in_ready, out_valid, is_multi, illegal, md_busy;
  logic [3:0]    alu_ctrl;
  logic [CW-1:0] md_count;

  int         checks = 0;
  int         failures = 0;
  logic [5:0] sb[$];
  logic [5:0] fn_tab[16];
  bit         rnd_done;

  always #5 clk = ~clk;

  alu_ctrl_pipe #(
    .ALUOP_W(3), .FUNCT_W(6), .CTRL_W(4), .MD_CYCLES(MD), .CNT_W(CW)
  ) dut (
    .clk(clk), .rstb(rstb), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .is_multi(is_multi), .illegal(illegal),
    .md_busy(md_busy), .md_count(md_count)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference decode: returns {is_multi, illegal, alu_ctrl}.
  function automatic logic [5:0] exp_dec(input logic [2:0] op, input logic [5:0] fn);
    case (op)
      3'd0: return {2'b00, C_ADD};
      3'd1: return {2'b00, C_SUB};
      3'd2: return {2'b00, C_AND};
      3'd3: return {2'b00, C_OR};
      3'd4: return {2'b00, C_XOR};
      3'd5: return {2'b00, C_SLT};
      default: begin
        case (fn)
          6'h24: return {2'b00, C_AND};
          6'h25: return {2'b00, C_OR};
          6'h26: return {2'b00, C_XOR};
          6'h27: return {2'b00, C_NOR};
          6'h00: return {2'b00, C_SLL};
          6'h02: return {2'b00, C_SRL};
          6'h03: return {2'b00, C_SRA};
          6'h2A: return {2'b00, C_SLT};
          6'h20: return {2'b00, C_ADD};
          6'h22: return {2'b00, C_SUB};
`ifdef ALU_CTRL_PIPE_MULDIV_EN
          6'h18: return {2'b10, C_MULT};
          6'h19: return {2'b10, C_MULTU};
          6'h1A: return {2'b10, C_DIV};
          6'h1B: return {2'b10, C_DIVU};
`endif
          default: return {2'b01, C_ADD};
        endcase
      end
    endcase
  endfunction

  // Present one request from posedge+1 until accepted; push its expected result on acceptance.
  task automatic send(input logic [2:0] op, input logic [5:0] fn);
    bit done = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    alu_op   = op;
    funct    = fn;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(exp_dec(op, fn));
        done = 1'b1;
      end else if (n > 200) begin
        check("send_timeout", 32'(in_ready), 1);
        done = 1'b1;
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
  endtask

  // Scoreboard: every handshaken result must match the oldest expectation.
  always @(negedge clk) begin
    logic [5:0] e;
    if (rstb && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(out_valid), 0);
      end else begin
        e = sb.pop_front();
        check("sb_result", 32'({is_multi, illegal, alu_ctrl}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fn_tab[0] = 6'h24; fn_tab[1] = 6'h25; fn_tab[2]  = 6'h26; fn_tab[3]  = 6'h27;
    fn_tab[4] = 6'h00; fn_tab[5] = 6'h02; fn_tab[6]  = 6'h03; fn_tab[7]  = 6'h2A;
    fn_tab[8] = 6'h20; fn_tab[9] = 6'h22; fn_tab[10] = 6'h18; fn_tab[11] = 6'h19;
    fn_tab[12] = 6'h1A; fn_tab[13] = 6'h1B; fn_tab[14] = 6'h3F; fn_tab[15] = 6'h21;

    // Reset state.
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_alu_ctrl", 32'(alu_ctrl), 32'(C_ADD));
    check("rst_is_multi", 32'(is_multi), 0);
    check("rst_illegal", 32'(illegal), 0);
    check("rst_md_busy", 32'(md_busy), 0);
    check("rst_md_count", 32'(md_count), 0);
    @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Direct ADD, latency 1.
    out_ready = 1'b1;
    send(3'd0, 6'h00);
    @(negedge clk);
    check("add_out_valid", 32'(out_valid), 1);
    check("add_alu_ctrl", 32'(alu_ctrl), 32'(C_ADD));
    check("add_illegal", 32'(illegal), 0);
    @(posedge clk); #1;

    // All direct ALUOps, back to back.
    for (int i = 0; i < 6; i++) send(3'(i), 6'h3F);
    // Funct table through both funct-path ALUOp codes.
    for (int i = 0; i < 16; i++) send((i % 2 == 0) ? 3'd6 : 3'd7, fn_tab[i]);
    repeat (MD + 3) @(posedge clk);
    #1;

    // Unrecognised funct.
    send(3'd6, 6'h3F);
    @(negedge clk);
    check("ill_alu_ctrl", 32'(alu_ctrl), 32'(C_ADD));
    check("ill_illegal", 32'(illegal), 1);
    @(posedge clk); #1;

    // NOR held under backpressure.
    out_ready = 1'b0;
    send(3'd6, 6'h27);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_alu_ctrl", 32'(alu_ctrl), 32'(C_NOR));
      check("hold_in_ready", 32'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

`ifdef ALU_CTRL_PIPE_MULDIV_EN
    // DIV multi-cycle sequence.
    send(3'd6, 6'h1A);
    for (int k = 0; k < MD; k++) begin
      @(negedge clk);
      check("div_md_busy", 32'(md_busy), 1);
      check("div_md_count", 32'(md_count), 32'(MD - 1 - k));
      check("div_out_valid", 32'(out_valid), 0);
      check("div_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk);
    check("div_done_valid", 32'(out_valid), 1);
    check("div_done_multi", 32'(is_multi), 1);
    check("div_done_ctrl", 32'(alu_ctrl), 32'(C_DIV));
    check("div_done_busy", 32'(md_busy), 0);
    @(posedge clk); #1;

    // Flush while BUSY at md_count==2.
    send(3'd6, 6'h18);
    @(posedge clk); #1;
    check("flush_pre_count", 32'(md_count), 2);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_md_busy", 32'(md_busy), 0);
    check("flush_md_count", 32'(md_count), 0);
    void'(sb.pop_back());
    for (int i = 0; i < MD + 2; i++) begin
      @(negedge clk);
      check("flush_no_valid", 32'(out_valid), 0);
    end
    @(posedge clk); #1;

    // Reset while BUSY.
    send(3'd6, 6'h1B);
    @(posedge clk); #2;
    rstb = 1'b0;
    #1;
    check("rbusy_md_busy", 32'(md_busy), 0);
    check("rbusy_md_count", 32'(md_count), 0);
    check("rbusy_out_valid", 32'(out_valid), 0);
    check("rbusy_alu_ctrl", 32'(alu_ctrl), 32'(C_ADD));
    void'(sb.pop_back());
    @(negedge clk); rstb = 1'b1;
    for (int i = 0; i < MD + 2; i++) begin
      @(negedge clk);
      check("rbusy_no_valid", 32'(out_valid), 0);
    end
    @(posedge clk); #1;
`else
    // MULT without the multi-cycle option is an illegal single-cycle op.
    send(3'd6, 6'h18);
    @(negedge clk);
    check("nomd_out_valid", 32'(out_valid), 1);
    check("nomd_illegal", 32'(illegal), 1);
    check("nomd_alu_ctrl", 32'(alu_ctrl), 32'(C_ADD));
    check("nomd_md_busy", 32'(md_busy), 0);
    check("nomd_is_multi", 32'(is_multi), 0);
    @(posedge clk); #1;
`endif

    // Flush a pending single-cycle result.
    out_ready = 1'b0;
    send(3'd4, 6'h00);
    flush = 1'b1;
    @(negedge clk);
    check("fl_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fl_out_valid", 32'(out_valid), 0);
    check("fl_alu_hold", 32'(alu_ctrl), 32'(C_XOR));
    check("fl_in_ready_after", 32'(in_ready), 1);
    void'(sb.pop_back());
    @(posedge clk); #1;

    // Asynchronous reset with a pending result.
    send(3'd6, 6'h03);
    #2;
    rstb = 1'b0;
    #1;
    check("ra_out_valid", 32'(out_valid), 0);
    check("ra_alu_ctrl", 32'(alu_ctrl), 32'(C_ADD));
    check("ra_illegal", 32'(illegal), 0);
    void'(sb.pop_back());
    @(negedge clk); rstb = 1'b1;
    @(negedge clk);
    check("ra_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Random traffic with random backpressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send(3'($urandom_range(0, 7)), fn_tab[$urandom_range(0, 15)]);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    repeat (3 * MD + 6) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
